// File: rtl/axicb_pkg.sv
// Shared crossbar helpers.
//   axicb_idx_t          : requester index type, wide enough for the largest crossbar (8).
//   axicb_idx_w()        : index width for a given requester count, minimum 1 bit.
//   axicb_onehot_to_idx(): index of the lowest set bit of a (zero-padded) one-hot vector.
package axicb_pkg;

    localparam int unsigned AXICB_MAX_REQ = 8;

    typedef logic [2:0] axicb_idx_t;

    function automatic int unsigned axicb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Lowest set bit wins so a malformed multi-hot grant still maps to one requester.
    function automatic axicb_idx_t axicb_onehot_to_idx(input logic [AXICB_MAX_REQ-1:0] oh);
        axicb_idx_t idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < AXICB_MAX_REQ; i++) begin
            if (oh[i] && !found) begin
                idx   = axicb_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axicb_order_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers.
//   aclk, areset (async, active-high), srst (sync clear, priority over push/pop)
//   push/din   : write when not full
//   pop/dout   : dout is the head entry; pop advances when not empty
//   full/empty : pointer-derived, no combinational path from push/pop
//   cnt        : occupancy, $clog2(DEPTH)+1 bits
module axicb_order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       srst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wp == rp);
    assign full    = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    assign cnt     = wp - rp;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wp <= '0;
            rp <= '0;
        end else if (srst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge aclk) begin
        if (push_ok && !srst) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axicb_resp_switch.sv
// Response-return switch: records arbitration winners in grant order and steers
// the single slave response stream back to them, one burst per entry.
//   aclk, areset (async, active-high), srst (sync clear)
//   grant_valid/grant : arbitration result to record; grant_full holds off the arbiter
//   s_valid/s_ready/s_last/s_data : slave response stream
//   m_valid/m_ready   : per-requester handshake; m_last/m_data are broadcast copies
//   ostd_cnt          : outstanding recorded grants
module axicb_resp_switch
    import axicb_pkg::*;
#(
    parameter int unsigned REQ_NB  = 4,
    parameter int unsigned OSTD_NB = 4,
    parameter int unsigned RESP_W  = 8
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        srst,
    input  logic                        grant_valid,
    input  logic [REQ_NB-1:0]           grant,
    output logic                        grant_full,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    input  logic [RESP_W-1:0]           s_data,
    output logic [REQ_NB-1:0]           m_valid,
    input  logic [REQ_NB-1:0]           m_ready,
    output logic                        m_last,
    output logic [RESP_W-1:0]           m_data,
    output logic [$clog2(OSTD_NB):0]    ostd_cnt
);

    localparam int unsigned IW = axicb_idx_w(REQ_NB);

    logic [AXICB_MAX_REQ-1:0] grant_pad;
    axicb_idx_t               grant_idx;
    logic [IW-1:0]            head;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     sel_ready;

    always_comb begin
        grant_pad             = '0;
        grant_pad[REQ_NB-1:0] = grant;
    end

    assign grant_idx = axicb_onehot_to_idx(grant_pad);
    assign push      = grant_valid & (|grant);
    assign pop       = s_valid & s_ready & s_last;

    axicb_order_fifo #(
        .DEPTH (OSTD_NB),
        .WIDTH (IW)
    ) u_order_fifo (
        .aclk   (aclk),
        .areset (areset),
        .srst   (srst),
        .push   (push),
        .din    (grant_idx[IW-1:0]),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .cnt    (ostd_cnt)
    );

    // Decode head and select its ready in one pass; nothing routes while empty.
    always_comb begin
        m_valid   = '0;
        sel_ready = 1'b0;
        for (int unsigned i = 0; i < REQ_NB; i++) begin
            if (head == IW'(i)) begin
                m_valid[i] = s_valid & ~empty;
                sel_ready  = m_ready[i];
            end
        end
    end

    assign s_ready    = ~empty & sel_ready;
    assign grant_full = full;
    assign m_last     = s_last;
    assign m_data     = s_data;

    a_no_grant_when_full : assert property (
        @(posedge aclk) disable iff (areset) grant_valid |-> !full
    ) else $error("grant_valid issued while order queue full");

    a_grant_onehot : assert property (
        @(posedge aclk) disable iff (areset) grant_valid |-> $onehot0(grant)
    ) else $error("grant not one-hot with grant_valid");

    a_resp_when_empty : assert property (
        @(posedge aclk) disable iff (areset || srst) s_valid |-> !empty
    ) else $warning("s_valid asserted with empty order queue");

endmodule

// File: tb/tb_axicb_resp_switch.sv
module tb_axicb_resp_switch;

    localparam int unsigned REQ_NB  = 4;
    localparam int unsigned OSTD_NB = 4;
    localparam int unsigned RESP_W  = 8;

    logic              aclk;
    logic              areset;
    logic              srst;
    logic              grant_valid;
    logic [REQ_NB-1:0] grant;
    logic              grant_full;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [RESP_W-1:0] s_data;
    logic [REQ_NB-1:0] m_valid;
    logic [REQ_NB-1:0] m_ready;
    logic              m_last;
    logic [RESP_W-1:0] m_data;
    logic [2:0]        ostd_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    axicb_resp_switch #(
        .REQ_NB  (REQ_NB),
        .OSTD_NB (OSTD_NB),
        .RESP_W  (RESP_W)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .srst        (srst),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_full  (grant_full),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_last      (s_last),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .m_data      (m_data),
        .ostd_cnt    (ostd_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [REQ_NB-1:0] head_onehot();
        logic [REQ_NB-1:0] oh;
        oh = '0;
        if (exp_q.size() > 0) oh[exp_q[0]] = 1'b1;
        return oh;
    endfunction

    task automatic do_grant(input int r);
        grant_valid = 1'b1;
        grant       = '0;
        grant[r]    = 1'b1;
        exp_q.push_back(r);
        tick();
        grant_valid = 1'b0;
        grant       = '0;
    endtask

    // Present one beat and hold it until accepted; checks routing against the scoreboard.
    task automatic beat(input logic last, input logic [RESP_W-1:0] d);
        int n;
        s_valid = 1'b1;
        s_last  = last;
        s_data  = d;
        for (n = 0; n < 20; n++) begin
            @(negedge aclk);
            if (s_ready === 1'b1) break;
            tick();
        end
        if (n == 20) begin
            check_eq("beat_timeout", 0, 1);
        end else begin
            check_eq("m_valid_route", 32'(m_valid), 32'(head_onehot()));
            check_eq("m_data",        32'(m_data), 32'(d));
            check_eq("m_last",        32'(m_last), 32'(last));
            check_eq("cnt_at_beat",   32'(ostd_cnt), 32'(exp_q.size()));
            check_eq("full_at_beat",  32'(grant_full), 32'(exp_q.size() == OSTD_NB));
            tick();
            if (last) void'(exp_q.pop_front());
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 16) begin
            beat(1'b1, RESP_W'($urandom));
            guard++;
        end
        @(negedge aclk);
        check_eq("cnt_drained", 32'(ostd_cnt), 0);
    endtask

    initial begin
        logic [5:0] pat;
        areset = 1'b1; srst = 1'b0;
        grant_valid = 1'b0; grant = '0;
        s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        m_ready = '1;

        // Reset state
        repeat (3) tick();
        s_valid = 1'b1; s_data = 8'h5a; s_last = 1'b1;
        @(negedge aclk);
        check_eq("rst_cnt",     32'(ostd_cnt), 0);
        check_eq("rst_full",    32'(grant_full), 0);
        check_eq("rst_s_ready", 32'(s_ready), 0);
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_m_data",  32'(m_data), 32'h5a);
        check_eq("rst_m_last",  32'(m_last), 1);
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        areset = 1'b0;
        tick();

        // In-order return of single-beat responses
        do_grant(0); do_grant(2); do_grant(1);
        @(negedge aclk);
        check_eq("order_cnt3", 32'(ostd_cnt), 3);
        tick();
        drain();

        // Burst routing with toggling requester ready
        do_grant(3);
        pat = 6'b101101;   // applied LSB first: 1,0,1,1,0,1
        begin
            int bt;
            bt = 0;
            for (int c = 0; c < 6; c++) begin
                m_ready    = 4'b0111;
                m_ready[3] = pat[c];
                s_valid    = 1'b1;
                s_last     = (bt == 3);
                s_data     = RESP_W'(8'h30 + bt);
                @(negedge aclk);
                check_eq("burst_s_ready", 32'(s_ready), 32'(pat[c]));
                check_eq("burst_m_valid", 32'(m_valid), 32'h8);
                check_eq("burst_cnt",     32'(ostd_cnt), 1);
                tick();
                if (pat[c]) bt++;
            end
            s_valid = 1'b0; s_last = 1'b0; m_ready = '1;
            void'(exp_q.pop_front());
            @(negedge aclk);
            check_eq("burst_popped", 32'(ostd_cnt), 0);
            tick();
        end

        // Full, pop, refill across pointer wrap
        do_grant(0); do_grant(1); do_grant(2); do_grant(3);
        @(negedge aclk);
        check_eq("full_set", 32'(grant_full), 1);
        check_eq("full_cnt", 32'(ostd_cnt), 4);
        tick();
        beat(1'b1, 8'ha0);
        @(negedge aclk);
        check_eq("full_cleared", 32'(grant_full), 0);
        check_eq("full_cnt3",    32'(ostd_cnt), 3);
        tick();
        do_grant(0);
        @(negedge aclk);
        check_eq("refull", 32'(grant_full), 1);
        tick();
        drain();
        tick();

        // Simultaneous push and pop at cnt=2
        do_grant(1); do_grant(2);
        grant_valid = 1'b1; grant = 4'b1000;
        s_valid = 1'b1; s_last = 1'b1; s_data = 8'h77;
        @(negedge aclk);
        check_eq("pp_s_ready", 32'(s_ready), 1);
        check_eq("pp_m_valid", 32'(m_valid), 32'h2);
        tick();
        exp_q.push_back(3);
        void'(exp_q.pop_front());
        grant_valid = 1'b0; grant = '0; s_valid = 1'b0; s_last = 1'b0;
        @(negedge aclk);
        check_eq("pp_cnt", 32'(ostd_cnt), 2);
        tick();
        drain();
        tick();

        // Empty: response not accepted until the cycle after the grant
        s_valid = 1'b1; s_last = 1'b1; s_data = 8'h11;
        @(negedge aclk);
        check_eq("empty_s_ready", 32'(s_ready), 0);
        check_eq("empty_m_valid", 32'(m_valid), 0);
        tick();
        grant_valid = 1'b1; grant = 4'b0100;
        @(negedge aclk);
        check_eq("grant_cycle_s_ready", 32'(s_ready), 0);
        check_eq("grant_cycle_m_valid", 32'(m_valid), 0);
        tick();
        exp_q.push_back(2);
        grant_valid = 1'b0; grant = '0;
        @(negedge aclk);
        check_eq("next_cycle_s_ready", 32'(s_ready), 1);
        check_eq("next_cycle_m_valid", 32'(m_valid), 32'h4);
        tick();
        void'(exp_q.pop_front());
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge aclk);
        check_eq("empty_cnt", 32'(ostd_cnt), 0);
        tick();

        // srst mid-burst with 3 outstanding
        do_grant(0); do_grant(1); do_grant(2);
        beat(1'b0, 8'hc0);
        s_valid = 1'b1; s_last = 1'b0; s_data = 8'hc1;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        exp_q.delete();
        @(negedge aclk);
        check_eq("srst_cnt",     32'(ostd_cnt), 0);
        check_eq("srst_s_ready", 32'(s_ready), 0);
        check_eq("srst_full",    32'(grant_full), 0);
        tick();
        s_valid = 1'b0;
        do_grant(3);
        beat(1'b1, 8'hd0);
        @(negedge aclk);
        check_eq("post_srst_cnt", 32'(ostd_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
